// File: rtl/itcm_icb_responder_pkg.sv
// Shared width constants for the ITCM fetch-side ICB responder.
package itcm_icb_responder_pkg;
    localparam int E203_ITCM_ADDR_WIDTH = 16;
    localparam int E203_ITCM_DATA_WIDTH = 64;
    localparam int E203_ITCM_RAM_DEPTH  = 8192;
endpackage

// File: rtl/itcm_rsp_fifo.sv
// Two-entry response skid FIFO; holds {err, data} while the IFU stalls rsp_ready.
module itcm_rsp_fifo #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty,
    output logic [1:0]   cnt
);
    logic [W-1:0] mem [2];
    logic         wptr;
    logic         rptr;
    logic         do_push;
    logic         do_pop;

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= 1'b0;
            rptr <= 1'b0;
            cnt  <= 2'd0;
        end else begin
            if (do_push) begin
                wptr <= ~wptr;
            end
            if (do_pop) begin
                rptr <= ~rptr;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/itcm_icb_responder.sv
// ICB responder toward the ITCM SRAM: single-cycle read latency, in-order
// responses, error answers for writes and out-of-range reads.
module itcm_icb_responder
    import itcm_icb_responder_pkg::*;
#(
    parameter int ADDR_W    = E203_ITCM_ADDR_WIDTH,
    parameter int DATA_W    = E203_ITCM_DATA_WIDTH,
    parameter int RAM_DEPTH = E203_ITCM_RAM_DEPTH,
    localparam int RAM_AW   = $clog2(RAM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icb_cmd_valid,
    output logic              icb_cmd_ready,
    input  logic [ADDR_W-1:0] icb_cmd_addr,
    input  logic              icb_cmd_read,
    output logic              icb_rsp_valid,
    input  logic              icb_rsp_ready,
    output logic              icb_rsp_err,
    output logic [DATA_W-1:0] icb_rsp_rdata,
    output logic              ram_cs,
    output logic [RAM_AW-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              idle
);
    logic [ADDR_W-4:0] widx;
    logic              cmd_err;
    logic              accept;
    logic              s1_vld;
    logic              s1_err;
    logic [2:0]        occupancy;
    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W:0]   fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_cnt;
    logic              src_err;
    logic [DATA_W-1:0] src_data;
    logic              s1_err_unused_lo;

    assign s1_err_unused_lo = ^{icb_cmd_addr[2:0], fifo_full};

    assign widx    = icb_cmd_addr[ADDR_W-1:3];
    assign cmd_err = ~icb_cmd_read | (32'(widx) >= 32'(RAM_DEPTH));

    // Ready depends only on registered occupancy, never on rsp_ready.
    assign occupancy     = {1'b0, fifo_cnt} + {2'b00, s1_vld};
    assign icb_cmd_ready = ~rst & (occupancy < 3'd2);
    assign accept        = icb_cmd_valid & icb_cmd_ready;

    assign ram_cs   = accept & ~cmd_err;
    assign ram_addr = widx[RAM_AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_err <= 1'b0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_err <= cmd_err;
            end
        end
    end

    // S1 skips the FIFO only when it is presented directly and taken this cycle.
    assign fifo_push = ~rst & s1_vld & ~(fifo_empty & icb_rsp_ready);
    assign fifo_pop  = ~rst & ~fifo_empty & icb_rsp_ready;

    itcm_rsp_fifo #(
        .W (DATA_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .push_data ({s1_err, (s1_err ? {DATA_W{1'b0}} : ram_dout)}),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .cnt       (fifo_cnt)
    );

    assign src_err  = fifo_empty ? s1_err : fifo_head[DATA_W];
    assign src_data = fifo_empty ? ram_dout : fifo_head[DATA_W-1:0];

    assign icb_rsp_valid = ~rst & (s1_vld | ~fifo_empty);
    assign icb_rsp_err   = icb_rsp_valid & src_err;
    assign icb_rsp_rdata = (icb_rsp_valid & ~src_err) ? src_data : {DATA_W{1'b0}};

    assign idle = ~s1_vld & fifo_empty;
endmodule

// File: tb/tb_itcm_icb_responder.sv
// Self-checking bench for itcm_icb_responder with a behavioural SRAM and an
// in-order response scoreboard.
module tb_itcm_icb_responder;
    localparam int ADDR_W    = 17;
    localparam int DATA_W    = 64;
    localparam int RAM_DEPTH = 8192;
    localparam int RAM_AW    = 13;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_read;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_err;
    logic [DATA_W-1:0] rdata;
    logic              ram_cs;
    logic [RAM_AW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dout;
    logic              idle;

    int errors = 0;
    int checks = 0;

    logic [DATA_W:0] exp_q[$];
    logic            cmd_fire = 1'b0;
    logic            rsp_fire = 1'b0;
    logic            stall_prev = 1'b0;
    logic            prev_err;
    logic [DATA_W-1:0] prev_data;

    itcm_icb_responder #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RAM_DEPTH (RAM_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .icb_cmd_valid (cmd_valid),
        .icb_cmd_ready (cmd_ready),
        .icb_cmd_addr  (cmd_addr),
        .icb_cmd_read  (cmd_read),
        .icb_rsp_valid (rsp_valid),
        .icb_rsp_ready (rsp_ready),
        .icb_rsp_err   (rsp_err),
        .icb_rsp_rdata (rdata),
        .ram_cs        (ram_cs),
        .ram_addr      (ram_addr),
        .ram_dout      (ram_dout),
        .idle          (idle)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] word_val(input logic [RAM_AW-1:0] i);
        return 64'h1111_0000_0000_0000 + {51'b0, i};
    endfunction

    function automatic logic [DATA_W:0] expect_rsp(input logic [ADDR_W-1:0] a, input logic rd);
        logic [ADDR_W-4:0] w;
        logic e;
        w = a[ADDR_W-1:3];
        e = ~rd || (int'(w) >= RAM_DEPTH);
        return e ? {1'b1, {DATA_W{1'b0}}} : {1'b0, word_val(w[RAM_AW-1:0])};
    endfunction

    // SRAM: data one cycle after cs, junk otherwise
    always @(posedge clk) begin
        if (ram_cs) ram_dout <= word_val(ram_addr);
        else        ram_dout <= {$urandom, $urandom};
    end

    // scoreboard monitor
    always @(negedge clk) begin
        logic [DATA_W:0] e;
        if (rst) begin
            exp_q.delete();
            cmd_fire   = 1'b0;
            rsp_fire   = 1'b0;
            stall_prev = 1'b0;
        end else begin
            cmd_fire = cmd_valid & cmd_ready;
            rsp_fire = rsp_valid & rsp_ready;
            checks++;
            if (dut.u_fifo.cnt > 2'd2) begin
                errors++;
                $display("FAIL fifo_cnt: got %0d max 2", dut.u_fifo.cnt);
            end
            if (stall_prev) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_err !== prev_err || rdata !== prev_data) begin
                    errors++;
                    $display("FAIL rsp_stable: got v=%b e=%b d=%h required v=1 e=%b d=%h",
                             rsp_valid, rsp_err, rdata, prev_err, prev_data);
                end
            end
            if (!rsp_valid) begin
                checks++;
                if (rsp_err !== 1'b0 || rdata !== '0) begin
                    errors++;
                    $display("FAIL idle_rsp_zero: got e=%b d=%h required 0", rsp_err, rdata);
                end
            end
            if (rsp_fire) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got e=%b d=%h with nothing outstanding", rsp_err, rdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_err, rdata} !== e) begin
                        errors++;
                        $display("FAIL sb_order: got %h required %h", {rsp_err, rdata}, e);
                    end
                end
            end
            if (cmd_fire) begin
                e = expect_rsp(cmd_addr, cmd_read);
                checks++;
                if (ram_cs !== ~e[DATA_W] || (!e[DATA_W] && ram_addr !== cmd_addr[RAM_AW+2:3])) begin
                    errors++;
                    $display("FAIL ram_strobe: got cs=%b addr=%h for cmd %h rd=%b",
                             ram_cs, ram_addr, cmd_addr, cmd_read);
                end
                exp_q.push_back(e);
            end else begin
                checks++;
                if (ram_cs !== 1'b0) begin
                    errors++;
                    $display("FAIL ram_cs_idle: got %b required 0", ram_cs);
                end
            end
            stall_prev = rsp_valid & ~rsp_ready;
            prev_err   = rsp_err;
            prev_data  = rdata;
        end
    end

    // driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = '0; rsp_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (ram_cs !== 1'b0 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: got cs=%b rsp_valid=%b required 0 0", ram_cs, rsp_valid);
            end
        end
        tick();
        rst = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || idle !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rdata !== '0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b idle=%b v=%b e=%b d=%h required 1 1 0 0 0",
                     cmd_ready, idle, rsp_valid, rsp_err, rdata);
        end
        tick();
    endtask

    task automatic test_throughput();
        rsp_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            cmd_valid = (i < 8);
            cmd_read  = 1'b1;
            cmd_addr  = ADDR_W'(i * 8);
            @(negedge clk);
            if (i < 8) begin
                checks++;
                if (cmd_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL tput_ready: beat %0d got %b required 1", i, cmd_ready);
                end
            end
            if (i > 0) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rdata !== word_val(RAM_AW'(i - 1))) begin
                    errors++;
                    $display("FAIL tput_rsp: beat %0d got v=%b e=%b d=%h required 1 0 %h",
                             i - 1, rsp_valid, rsp_err, rdata, word_val(RAM_AW'(i - 1)));
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int n_acc;
        n_acc = 0;
        rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 17'h00100;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (cmd_fire) begin
                n_acc++;
                cmd_addr = cmd_addr + 17'd8;
            end
        end
        @(negedge clk);
        checks++;
        if (n_acc != 2 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: got accepts=%0d rdy=%b required 2 0", n_acc, cmd_ready);
        end
        rsp_ready = 1'b1;
        n_acc = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (cmd_fire) begin
                n_acc++;
                cmd_addr = cmd_addr + 17'd8;
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (n_acc != 9) begin
            errors++;
            $display("FAIL bp_resume: got accepts=%0d required 9", n_acc);
        end
        for (int c = 0; c < 10 && !idle; c++) tick();
        @(negedge clk);
        checks++;
        if (idle !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: got idle=%b outstanding=%0d required 1 0", idle, exp_q.size());
        end
        tick();
    endtask

    task automatic test_errors();
        logic [ADDR_W-1:0] a_tab [4];
        logic              r_tab [4];
        logic [DATA_W:0]   e;
        a_tab[0] = 17'h00008; r_tab[0] = 1'b1;
        a_tab[1] = 17'h10000; r_tab[1] = 1'b1;
        a_tab[2] = 17'h00010; r_tab[2] = 1'b0;
        a_tab[3] = 17'h00018; r_tab[3] = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            cmd_valid = (i < 4);
            if (i < 4) begin
                cmd_addr = a_tab[i];
                cmd_read = r_tab[i];
            end
            @(negedge clk);
            if (i < 4) begin
                checks++;
                if (cmd_ready !== 1'b1 || ram_cs !== (i == 0 || i == 3)) begin
                    errors++;
                    $display("FAIL err_cs: cmd %0d got rdy=%b cs=%b", i, cmd_ready, ram_cs);
                end
            end
            if (i > 0) begin
                e = (i - 1 == 0) ? {1'b0, word_val(13'd1)} :
                    (i - 1 == 3) ? {1'b0, word_val(13'd3)} : {1'b1, 64'd0};
                checks++;
                if (rsp_valid !== 1'b1 || {rsp_err, rdata} !== e) begin
                    errors++;
                    $display("FAIL err_rsp: cmd %0d got v=%b %h required %h", i - 1, rsp_valid, {rsp_err, rdata}, e);
                end
            end
            tick();
        end
    endtask

    task automatic test_low_bits();
        rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 17'h0000A;
        @(negedge clk);
        checks++;
        if (ram_cs !== 1'b1 || ram_addr !== 13'd1) begin
            errors++;
            $display("FAIL low_bits_addr: got cs=%b addr=%0d required 1 1", ram_cs, ram_addr);
        end
        tick();
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rdata !== word_val(13'd1)) begin
            errors++;
            $display("FAIL low_bits_data: got v=%b e=%b d=%h required 1 0 %h", rsp_valid, rsp_err, rdata, word_val(13'd1));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 17'h00040;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (cmd_fire) cmd_addr = cmd_addr + 17'd8;
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || idle !== 1'b0 || exp_q.size() != 2) begin
            errors++;
            $display("FAIL rmid_buffered: got v=%b idle=%b outstanding=%0d required 1 0 2", rsp_valid, idle, exp_q.size());
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || idle !== 1'b1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_after: got v=%b idle=%b rdy=%b required 0 1 1", rsp_valid, idle, cmd_ready);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rmid_stale: cycle %0d got rsp_valid=%b required 0", c, rsp_valid);
            end
        end
        tick();
    endtask

    task automatic test_random();
        int n_cmd;
        int guard;
        n_cmd = 0;
        guard = 0;
        cmd_valid = 1'b0;
        while (n_cmd < 10000 && guard < 60000) begin
            if (!cmd_valid || cmd_fire) begin
                cmd_valid = ($urandom_range(0, 3) != 0);
                cmd_read  = ($urandom_range(0, 15) != 0);
                cmd_addr  = {($urandom_range(0, 15) == 0), 16'($urandom)};
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
            guard++;
            if (cmd_fire) n_cmd++;
        end
        checks++;
        if (n_cmd < 10000) begin
            errors++;
            $display("FAIL rand_progress: got %0d commands required 10000", n_cmd);
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        for (int c = 0; c < 20 && !idle; c++) tick();
        @(negedge clk);
        checks++;
        if (idle !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_drain: got idle=%b outstanding=%0d required 1 0", idle, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_throughput();
        test_backpressure();
        test_errors();
        test_low_bits();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
